data_memory_responder: RTL and testbench

- Synchronous, handshaked responder for the processor's data memory interface (Address, r_wbar, WriteData, ReadData).
- It is the memory end of the load/store path: it accepts one request at a time from the load/store initiator.
- It holds a word-indexed array, waits a programmable number of cycles, then returns read data or a write acknowledge with a one-cycle response strobe.

---
 rtl/data_memory_responder.sv | 119 +++++++++++
 tb/tb_data_memory_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// Word-indexed data memory with a programmable response delay and a one-request-at-a-time handshake.
// Optional out-of-range checking on Address[31:AW] is enabled by defining DMEM_RANGE_CHECK_EN.
module data_memory_responder #(
  parameter int DEPTH   = 64,
  parameter int AW      = 6,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Req,
  input  logic [31:0] Address,
  input  logic        r_wbar,
  input  logic [31:0] WriteData,
  output logic        Ready,
  output logic        RespValid,
  output logic [31:0] ReadData,
  output logic        Error
);

  localparam logic [3:0] WAIT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          rd_q, rd_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          oob_q, oob_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   mem_q [DEPTH];
  logic          mem_we;
  logic          req_oob;

`ifdef DMEM_RANGE_CHECK_EN
  assign req_oob = |Address[31:AW];
`else
  logic addr_hi_unused;
  assign addr_hi_unused = |Address[31:AW];
  assign req_oob        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rd_d    = rd_q;
    wdata_d = wdata_q;
    oob_d   = oob_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (Req) begin
          idx_d   = Address[AW-1:0];
          rd_d    = r_wbar;
          wdata_d = WriteData;
          oob_d   = req_oob;
          cnt_d   = WAIT_INIT;
          state_d = (LATENCY == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP: begin
        state_d = S_IDLE;
        mem_we  = ~rd_q & ~oob_q;
      end
      default: state_d = S_IDLE;
    endcase
    // Response data is latched on entry to RESP so it holds afterwards.
    if (state_d == S_RESP) begin
      if (oob_d)     rdata_d = 32'hDEADBEEF;
      else if (rd_d) rdata_d = mem_q[idx_d];
      else           rdata_d = wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      rd_q    <= 1'b0;
      wdata_q <= '0;
      oob_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rd_q    <= rd_d;
      wdata_q <= wdata_d;
      oob_q   <= oob_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  // A reset landing on the RESP cycle suppresses the strobe as well.
  assign Ready     = (state_q == S_IDLE);
  assign RespValid = (state_q == S_RESP) & rst_n;
  assign Error     = RespValid & oob_q;
  assign ReadData  = rdata_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: LATENCY=2 instance with randomized traffic, plus a
// LATENCY=0 instance exercising a continuously held Req.
module tb_data_memory_responder;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        req = 1'b0, rw = 1'b1;
  logic [31:0] addr = '0, wd = '0;
  logic        rdy, rv, err;
  logic [31:0] rd;

  logic        req0 = 1'b0, rw0 = 1'b1;
  logic [31:0] addr0 = '0, wd0 = '0;
  logic        rdy0, rv0, err0;
  logic [31:0] rd0;

  data_memory_responder #(.DEPTH(DEPTH), .AW(AW), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n), .Req(req), .Address(addr), .r_wbar(rw), .WriteData(wd),
    .Ready(rdy), .RespValid(rv), .ReadData(rd), .Error(err));

  data_memory_responder #(.DEPTH(DEPTH), .AW(AW), .LATENCY(0)) u_dut_l0 (
    .clk(clk), .rst_n(rst_n), .Req(req0), .Address(addr0), .r_wbar(rw0), .WriteData(wd0),
    .Ready(rdy0), .RespValid(rv0), .ReadData(rd0), .Error(err0));

  int total = 0, bad = 0, cyc = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t        sbq[$];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] hist [16];
  logic [31:0] rb_addr [5];
  logic [31:0] rb_exp [5];
  int          nresp;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void check1(string name, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every response strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (rv) begin
        if (sbq.size() == 0) begin
          check1("spurious_resp", rv, 1'b0);
        end else begin
          e = sbq.pop_front();
          check("resp_data", rd, e.data);
          check1("resp_err", err, e.err);
          check("resp_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else begin
        check1("err_idle", err, 1'b0);
      end
    end
  end

  task automatic clear_model();
    sbq.delete();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  task automatic do_req(input logic r, input logic [31:0] a, input logic [31:0] d);
    int   n;
    int   idx;
    logic oob;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy) begin
      check1("ready_timeout", rdy, 1'b1);
      return;
    end
    req = 1'b1; rw = r; addr = a; wd = d;
    idx = int'(a % DEPTH);
    oob = 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
    oob = (a / DEPTH) != 0;
`endif
    e.cyc = cyc + LAT + 1;
    e.err = oob;
    if (oob)    e.data = 32'hDEADBEEF;
    else if (r) e.data = ref_mem[idx];
    else begin
      e.data       = d;
      ref_mem[idx] = d;
    end
    sbq.push_back(e);
    @(negedge clk);
    req = 1'b0; addr = $urandom; wd = $urandom; rw = $urandom_range(0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    clear_model();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check1("rst_ready", rdy, 1'b1);
    check1("rst_valid", rv, 1'b0);
    check("rst_rdata", rd, 32'd0);
    check1("rst_err", err, 1'b0);

    do_req(1'b1, 32'd1, 32'd0);
    do_req(1'b0, 32'd17, 32'h71FD6806);
    do_req(1'b1, 32'd17, 32'd0);
    do_req(1'b1, 32'd13, 32'd0);

    // Inputs changing while busy must not disturb the captured write to word 5.
    do_req(1'b0, 32'd5, 32'hC0FFEE05);
    req = 1'b1; rw = 1'b0; addr = 32'd7; wd = 32'hBAD0BAD0;
    check1("ready_in_wait0", rdy, 1'b0);
    @(negedge clk);
    check1("ready_in_wait1", rdy, 1'b0);
    wd = 32'h0BADF00D;
    @(negedge clk);
    req = 1'b0;
    do_req(1'b1, 32'd5, 32'd0);
    do_req(1'b1, 32'd7, 32'd0);
    drain();

    // Reset during WAIT of a write: no response, nothing committed, memory cleared.
    do_req(1'b0, 32'd9, 32'h12345678);
    rst_n = 1'b0;
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 2) @(negedge clk);
    do_req(1'b1, 32'd9, 32'd0);
    do_req(1'b1, 32'd17, 32'd0);
    do_req(1'b1, 32'd5, 32'd0);

    do_req(1'b0, 32'd64, 32'hAAAA5555);
    do_req(1'b1, 32'd0, 32'd0);
    do_req(1'b1, 32'd64, 32'd0);

    for (int i = 0; i < 40; i++) begin
      a = 32'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) a = a + 32'(DEPTH * $urandom_range(1, 1000));
      do_req(1'($urandom_range(0, 1)), a, $urandom);
    end
    do_req(1'b1, 32'd0, 32'd0);
    drain();

    // LATENCY=0 with Req held high: accepted every 2nd cycle, each answered next cycle.
    @(negedge clk);
    nresp = 0;
    for (int k = 0; k <= 8; k++) begin
      check1("l0w_ready", rdy0, (k % 2) == 0);
      check1("l0w_valid", rv0, (k % 2) == 1);
      check1("l0w_err", err0, 1'b0);
      if (rv0 && k > 0) begin
        nresp++;
        check("l0w_echo", rd0, hist[k-1]);
      end
      req0 = (k < 8);
      rw0  = 1'b0;
      addr0 = ((k % 2) == 0) ? 32'(20 + k / 2) : 32'd40;
      wd0  = $urandom;
      hist[k] = wd0;
      @(negedge clk);
    end
    check("l0w_count", 32'(nresp), 32'd4);

    rb_addr[0] = 32'd20; rb_addr[1] = 32'd21; rb_addr[2] = 32'd22;
    rb_addr[3] = 32'd23; rb_addr[4] = 32'd40;
    rb_exp[0] = hist[0]; rb_exp[1] = hist[2]; rb_exp[2] = hist[4];
    rb_exp[3] = hist[6]; rb_exp[4] = 32'd0;
    nresp = 0;
    for (int k = 0; k <= 10; k++) begin
      check1("l0r_ready", rdy0, (k % 2) == 0);
      check1("l0r_valid", rv0, (k % 2) == 1);
      if (rv0 && k > 0) begin
        nresp++;
        check("l0r_data", rd0, rb_exp[(k-1)/2]);
      end
      req0 = (k < 10);
      rw0  = 1'b1;
      addr0 = ((k % 2) == 0 && k < 10) ? rb_addr[k/2] : 32'd21;
      @(negedge clk);
    end
    check("l0r_count", 32'(nresp), 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
